// File: rtl/lt24_scene_pkg.sv
// Scene encoding, colour width and coordinate clamp helper shared by the LT24 compositor.
package lt24_scene_pkg;

  typedef enum logic [1:0] {
    SCENE_SPLASH = 2'd0,
    SCENE_INTRO  = 2'd1,
    SCENE_GAME   = 2'd2,
    SCENE_OVER   = 2'd3
  } sceneT;

  localparam int COLOUR_BITS = 16;

  function automatic int clampRange(input int value, input int maxValue);
    if (value < 0) begin
      return 0;
    end else if (value > maxValue) begin
      return maxValue;
    end
    return value;
  endfunction

endpackage

// File: rtl/lt24_cursor_clamp.sv
// One cursor axis: accumulates signed mouse deltas and saturates at 0 and MAX_POS.
module lt24_cursor_clamp
  import lt24_scene_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int MAX_POS   = 239,
  parameter int RESET_POS = 120
) (
  input  logic            clock,
  input  logic            globalReset,
  input  logic            update,
  input  logic [8:0]      delta,
  output logic [BITS-1:0] pos
);

  logic signed [BITS+1:0] sum;
  int                     clamped;

  // Two guard bits keep both underflow and overflow visible before clamping.
  assign sum = $signed({2'b00, pos}) + (BITS+2)'($signed(delta));

  always_comb begin
    clamped = clampRange(int'(sum), MAX_POS);
  end

  always_ff @(posedge clock) begin
    if (globalReset) begin
      pos <= BITS'(RESET_POS);
    end else if (update) begin
      pos <= BITS'(clamped);
    end
  end

endmodule

// File: rtl/lt24_scene_compositor.sv
// LT24 raster scan, clamped cursor, timed scene FSM and layer compositor.
// Build option SCENE_FRAME_SYNC_EN defers every scene change to the next frame start.
//
// state        | meaning
// SCENE_SPLASH | splash screen, timed by SPLASH_CYCLES or skipped
// SCENE_INTRO  | intro screen, timed by INTRO_CYCLES or skipped
// SCENE_GAME   | gameplay until gameOver
// SCENE_OVER   | game-over screen until skipScene restarts the game
module lt24_scene_compositor
  import lt24_scene_pkg::*;
#(
  parameter int          WIDTH         = 240,
  parameter int          HEIGHT        = 320,
  parameter int          XBITS         = 8,
  parameter int          YBITS         = 9,
  parameter int          NUM_LAYERS    = 4,
  parameter int          CURSOR_SIZE   = 4,
  parameter logic [15:0] CURSOR_COLOUR = 16'hFFFF,
  parameter int          SPLASH_CYCLES = 475000000,
  parameter int          INTRO_CYCLES  = 150000000,
  parameter int          TIMER_BITS    = 31
) (
  input  logic                              clock,
  input  logic                              globalReset,
  input  logic                              pixelReady,
  output logic [XBITS-1:0]                  xAddr,
  output logic [YBITS-1:0]                  yAddr,
  output logic                              frameStart,
  input  logic                              mouseDone,
  input  logic [8:0]                        mouseDx,
  input  logic [8:0]                        mouseDy,
  output logic [XBITS-1:0]                  cursorX,
  output logic [YBITS-1:0]                  cursorY,
  input  logic                              skipScene,
  input  logic                              gameOver,
  input  logic [NUM_LAYERS-1:0]             layerEn,
  input  logic [COLOUR_BITS*NUM_LAYERS-1:0] layerData,
  input  logic [COLOUR_BITS-1:0]            backgroundData,
  output logic [COLOUR_BITS-1:0]            pixelData,
  output logic [1:0]                        sceneState,
  output logic                              sceneEnterGame
);

  logic                  lastX;
  logic                  lastY;
  logic                  wrapNow;
  sceneT                 scene;
  logic [TIMER_BITS-1:0] timer;
  logic                  splashDone;
  logic                  introDone;
  logic                  inPlay;
  logic                  cursorHit;

  assign lastX      = (xAddr == XBITS'(WIDTH - 1));
  assign lastY      = (yAddr == YBITS'(HEIGHT - 1));
  assign wrapNow    = pixelReady && lastX && lastY;
  assign splashDone = (timer == TIMER_BITS'(SPLASH_CYCLES - 1));
  assign introDone  = (timer == TIMER_BITS'(INTRO_CYCLES - 1));
  assign sceneState = scene;
  assign inPlay     = (scene == SCENE_GAME) || (scene == SCENE_OVER);

  always_ff @(posedge clock) begin
    if (globalReset) begin
      xAddr      <= '0;
      yAddr      <= '0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= wrapNow;
      if (pixelReady) begin
        if (lastX) begin
          xAddr <= '0;
          yAddr <= lastY ? '0 : yAddr + YBITS'(1);
        end else begin
          xAddr <= xAddr + XBITS'(1);
        end
      end
    end
  end

  lt24_cursor_clamp #(
    .BITS      (XBITS),
    .MAX_POS   (WIDTH - 1),
    .RESET_POS (WIDTH / 2)
  ) uCursorX (
    .clock       (clock),
    .globalReset (globalReset),
    .update      (mouseDone),
    .delta       (mouseDx),
    .pos         (cursorX)
  );

  lt24_cursor_clamp #(
    .BITS      (YBITS),
    .MAX_POS   (HEIGHT - 1),
    .RESET_POS (HEIGHT / 2)
  ) uCursorY (
    .clock       (clock),
    .globalReset (globalReset),
    .update      (mouseDone),
    .delta       (mouseDy),
    .pos         (cursorY)
  );

`ifdef SCENE_FRAME_SYNC_EN
  logic  pending;
  sceneT pendingScene;

  // Requests are latched and only take effect on the raster wrap, so a frame never mixes scenes.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      scene          <= SCENE_SPLASH;
      timer          <= '0;
      pending        <= 1'b0;
      pendingScene   <= SCENE_SPLASH;
      sceneEnterGame <= 1'b0;
    end else begin
      sceneEnterGame <= 1'b0;
      if (pending) begin
        if (wrapNow) begin
          scene          <= pendingScene;
          pending        <= 1'b0;
          timer          <= '0;
          sceneEnterGame <= (pendingScene == SCENE_GAME);
        end
      end else begin
        case (scene)
          SCENE_SPLASH: begin
            if (skipScene || splashDone) begin
              pending      <= 1'b1;
              pendingScene <= SCENE_INTRO;
            end else begin
              timer <= timer + TIMER_BITS'(1);
            end
          end
          SCENE_INTRO: begin
            if (skipScene || introDone) begin
              pending      <= 1'b1;
              pendingScene <= SCENE_GAME;
            end else begin
              timer <= timer + TIMER_BITS'(1);
            end
          end
          SCENE_GAME: begin
            if (gameOver) begin
              pending      <= 1'b1;
              pendingScene <= SCENE_OVER;
            end
          end
          SCENE_OVER: begin
            if (skipScene) begin
              pending      <= 1'b1;
              pendingScene <= SCENE_GAME;
            end
          end
          default: begin
            pending      <= 1'b1;
            pendingScene <= SCENE_SPLASH;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (globalReset) begin
      scene          <= SCENE_SPLASH;
      timer          <= '0;
      sceneEnterGame <= 1'b0;
    end else begin
      sceneEnterGame <= 1'b0;
      case (scene)
        SCENE_SPLASH: begin
          if (skipScene || splashDone) begin
            scene <= SCENE_INTRO;
            timer <= '0;
          end else begin
            timer <= timer + TIMER_BITS'(1);
          end
        end
        SCENE_INTRO: begin
          if (skipScene || introDone) begin
            scene          <= SCENE_GAME;
            timer          <= '0;
            sceneEnterGame <= 1'b1;
          end else begin
            timer <= timer + TIMER_BITS'(1);
          end
        end
        SCENE_GAME: begin
          if (gameOver) begin
            scene <= SCENE_OVER;
          end
        end
        SCENE_OVER: begin
          if (skipScene) begin
            scene          <= SCENE_GAME;
            sceneEnterGame <= 1'b1;
          end
        end
        default: begin
          scene <= SCENE_SPLASH;
          timer <= '0;
        end
      endcase
    end
  end
`endif

  // Widened compares let the cursor box clip at the right/bottom edge instead of wrapping.
  assign cursorHit = inPlay
      && ({2'b00, xAddr} >= {2'b00, cursorX})
      && ({2'b00, xAddr} <  ({2'b00, cursorX} + (XBITS+2)'(CURSOR_SIZE)))
      && ({2'b00, yAddr} >= {2'b00, cursorY})
      && ({2'b00, yAddr} <  ({2'b00, cursorY} + (YBITS+2)'(CURSOR_SIZE)));

  always_comb begin
    pixelData = backgroundData;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerEn[i] && ((i == 0) || inPlay)) begin
        pixelData = layerData[COLOUR_BITS*i +: COLOUR_BITS];
      end
    end
    if (cursorHit) begin
      pixelData = CURSOR_COLOUR;
    end
  end

endmodule
